ahb_rom_arb2: RTL and testbench
===============================

# ahb_rom_arb2

Two-port AHB-Lite ROM arbiter: two independent AHB-Lite slave ports (port 0 = instruction side, port 1 = data side) share one synchronous single-port ROM macro. Each ROM read costs one ROM cycle; the losing port of a same-cycle conflict is stalled one wait state and then served from a captured address. Writes to either port get a two-cycle ERROR response without touching the ROM. Sits between the bus matrix and the ROM macro, replacing a single-port ROM slave interface.

## Interface
- p_AW, 15, byte-address width of ROM space; ROM word address is haddr[p_AW-1:2]
- hclk  in  1  system bus clock, all state on rising edge
- hresetn  in  1  asynchronous active-low reset
- hsel_n, hready_n  in  1  (n = 0,1) port select, bus ready input
- htrans_n  in  2  transfer type; only bit 1 (NONSEQ/SEQ) qualifies an access
- hwrite_n  in  1  write indicator
- haddr_n  in  32  address
- hreadyout_n  out  1  port ready output
- hresp_n  out  2  {1'b0, error}
- hrdata_n  out  32  read data (= rom_rdata on both ports)
- rom_rdata  in  32  ROM data, valid the cycle after rom_cs
- rom_addr  out  p_AW-2  ROM word address
- rom_cs  out  1  ROM chip select, active high

## Operation
- Access on port n: acc_n = hsel_n & hready_n & htrans_n[1]; read if ~hwrite_n, write otherwise.
- Per-port FSM: IDLE, DATA (ROM data returning, hreadyout=1), WAIT (stalled, hreadyout=0, captured address held), ERR1 (hreadyout=0, hresp=1), ERR2 (hreadyout=1, hresp=1).
- IDLE/DATA/ERR2 + write acc -> ERR1 -> ERR2 -> IDLE (or next state per new acc in ERR2).
- IDLE/DATA/ERR2 + read acc: granted -> DATA; not granted -> WAIT (capture haddr_n[p_AW-1:2]).
- WAIT -> DATA unconditionally next cycle (pending always granted).
- No acc -> IDLE; htrans IDLE/BUSY with hsel gets zero-wait OKAY.
- Grant priority per cycle: (1) port in WAIT; (2) single new read; (3) both new reads -> round-robin pointer rr; after every granted ROM cycle rr points to the other port.
- Invariant: never both ports in WAIT (a WAIT port always wins the next cycle).
- rom_cs = any grant (combinational); rom_addr = captured address if WAIT port granted, else haddr of granted port; rom_addr = 0 when rom_cs = 0.

## Timing
- Reset values: hreadyout_n=1, hresp_n=0, rom_cs=0, rom_addr=0, both FSMs IDLE, rr=0, captured addresses 0.
- Uncontended read: address phase cycle T drives rom_cs; data returned and hreadyout=1 at T+1 (zero wait).
- Contended loser: hreadyout=0 at T+1, ROM accessed at T+1, data with hreadyout=1 at T+2 (one wait).
- Write: ERROR over T+1 (hreadyout=0) and T+2 (hreadyout=1), hresp=1 both cycles; ROM untouched.
- Reset asserted mid-transfer: all FSMs to IDLE, outputs to reset values immediately; in-flight data discarded.

## Configuration
- ROM_ARB_FIXED_PRI_EN defined: simultaneous new reads always grant port 0; rr register not built. Undefined: round-robin as above. WAIT-first priority holds in both.

## Structure
- Package rom_arb_pkg: port FSM state enum, HTRANS/HRESP constants, port index constants.
- Sub-module ahb_rom_arb_port: one port's FSM, address capture, hreadyout/hresp generation; instantiated twice. Grant, rr and ROM muxing live in the top.

## Test plan
- Port 0 reads 0x0000_0010 alone -> rom_cs=1, rom_addr=0x004 at T; hrdata_0=rom_rdata, hreadyout_0=1 at T+1.
- Both read simultaneously (0x20, 0x40), rr=0 -> port 0 served at T (addr 0x008), port 1 hreadyout=0 at T+1, ROM addr 0x010 at T+1, port 1 data at T+2; rr=0 again afterwards.
- Port 1 in WAIT while port 0 issues new read 0x80 -> port 1 served, port 0 enters WAIT; alternating back-to-back streams on both ports sustain one ROM access per cycle, never both in WAIT.
- Port 1 write to 0x100 -> hresp_1=1 for 2 cycles, hreadyout_1 0 then 1, rom_cs never asserted for it; concurrent port 0 read zero-wait.
- Reset asserted while port 1 in WAIT -> hreadyout_1=1, rom_cs=0 immediately; first read after release zero-wait.
- With ROM_ARB_FIXED_PRI_EN, two consecutive simultaneous conflicts -> port 0 wins both.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and constants for the two-port AHB-Lite ROM arbiter.
// Port FSM state enum, HTRANS/HRESP encodings, port index constants.
package rom_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } port_st_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

endpackage

// File: rtl/ahb_rom_arb2_if.sv
// ahb_rom_arb2_if: one AHB-Lite slave port (hsel/hready/htrans/hwrite/haddr in,
// hreadyout/hresp/hrdata out). master = bus matrix side, slave = ROM arbiter side.
interface ahb_rom_arb2_if;

  logic        hsel;
  logic        hready;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, hready, htrans, hwrite, haddr,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, hready, htrans, hwrite, haddr,
    output hreadyout, hresp, hrdata
  );

endinterface

// File: rtl/ahb_rom_arb_port.sv
// ahb_rom_arb_port: one AHB-Lite port FSM with address capture and hreadyout/hresp.
// Ports: hclk, hresetn, bus (slave), rom_rdata, grant in; rd_req, pend, req_addr out.
module ahb_rom_arb_port #(
  parameter int p_AW = 15
) (
  input  logic            hclk,
  input  logic            hresetn,
  ahb_rom_arb2_if.slave   bus,
  input  logic [31:0]     rom_rdata,
  input  logic            grant,
  output logic            rd_req,
  output logic            pend,
  output logic [p_AW-3:0] req_addr
);

  import rom_arb_pkg::*;

  port_st_e        st, nxt;
  logic            acc;
  logic            open_st;
  logic [p_AW-3:0] cap_addr;
  logic            unused_bits;

  assign acc = bus.hsel & bus.hready & bus.htrans[1];

  // Only states with hreadyout=1 may accept a new address phase.
  assign open_st = (st == ST_IDLE) | (st == ST_DATA) | (st == ST_ERR2);
  assign rd_req  = open_st & acc & ~bus.hwrite;

  always_comb begin
    nxt = ST_IDLE;
    unique case (st)
      ST_WAIT: nxt = ST_DATA;
      ST_ERR1: nxt = ST_ERR2;
      default: begin
        if (acc) begin
          if (bus.hwrite)  nxt = ST_ERR1;
          else if (grant)  nxt = ST_DATA;
          else             nxt = ST_WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      st       <= ST_IDLE;
      cap_addr <= '0;
    end else begin
      st <= nxt;
      if (rd_req & ~grant)
        cap_addr <= bus.haddr[p_AW-1:2];
    end
  end

  assign pend     = (st == ST_WAIT);
  assign req_addr = pend ? cap_addr : bus.haddr[p_AW-1:2];

  assign bus.hreadyout = ~((st == ST_WAIT) | (st == ST_ERR1));
  assign bus.hresp     = ((st == ST_ERR1) | (st == ST_ERR2)) ?
                         HRESP_ERROR : HRESP_OKAY;
  assign bus.hrdata    = rom_rdata;

  assign unused_bits = ^{bus.htrans[0], bus.haddr[31:p_AW], bus.haddr[1:0]};

endmodule

// File: rtl/ahb_rom_arb2.sv
// ahb_rom_arb2: two AHB-Lite ports (p0 instr, p1 data) sharing one sync ROM; ports hclk,
// hresetn, p0/p1, rom_rdata, rom_addr, rom_cs. ROM_ARB_FIXED_PRI_EN: port 0 wins ties.
module ahb_rom_arb2 #(
  parameter int p_AW = 15
) (
  input  logic            hclk,
  input  logic            hresetn,
  ahb_rom_arb2_if.slave   p0,
  ahb_rom_arb2_if.slave   p1,
  input  logic [31:0]     rom_rdata,
  output logic [p_AW-3:0] rom_addr,
  output logic            rom_cs
);

  import rom_arb_pkg::*;

  logic [1:0]      req;
  logic [1:0]      pend;
  logic [1:0]      gnt;
  logic [p_AW-3:0] a0, a1;
  logic            tie_d;

  ahb_rom_arb_port #(.p_AW(p_AW)) u_port_i (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .bus       (p0),
    .rom_rdata (rom_rdata),
    .grant     (gnt[PORT_I]),
    .rd_req    (req[PORT_I]),
    .pend      (pend[PORT_I]),
    .req_addr  (a0)
  );

  ahb_rom_arb_port #(.p_AW(p_AW)) u_port_d (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .bus       (p1),
    .rom_rdata (rom_rdata),
    .grant     (gnt[PORT_D]),
    .rd_req    (req[PORT_D]),
    .pend      (pend[PORT_D]),
    .req_addr  (a1)
  );

  // A stalled port always wins, so two ports can never be in WAIT together.
  always_comb begin
    gnt = '0;
    unique case (1'b1)
      pend[PORT_I]: gnt[PORT_I] = 1'b1;
      pend[PORT_D]: gnt[PORT_D] = 1'b1;
      (&req): begin
        if (tie_d) gnt[PORT_D] = 1'b1;
        else       gnt[PORT_I] = 1'b1;
      end
      default: gnt = req;
    endcase
    if (!hresetn)
      gnt = '0;
  end

`ifdef ROM_ARB_FIXED_PRI_EN
  assign tie_d = 1'b0;
`else
  logic rr;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)
      rr <= 1'b0;
    else if (gnt[PORT_I])
      rr <= 1'b1;
    else if (gnt[PORT_D])
      rr <= 1'b0;
  end

  assign tie_d = rr;
`endif

  assign rom_cs   = |gnt;
  assign rom_addr = gnt[PORT_I] ? a0 :
                    gnt[PORT_D] ? a1 : '0;

endmodule

// File: tb/tb_ahb_rom_arb2.sv
// tb_ahb_rom_arb2: table-driven bench for ahb_rom_arb2 plus a reset-during-WAIT sequence.
// Each port's hready is tied to its own hreadyout; the ROM is a one-cycle model.
module tb_ahb_rom_arb2;

  localparam int AW = 15;
`ifdef ROM_ARB_FIXED_PRI_EN
  localparam bit FX = 1'b1;
`else
  localparam bit FX = 1'b0;
`endif

  localparam int OP_NONE = 0;
  localparam int OP_R    = 1;
  localparam int OP_W    = 2;
  localparam int OP_I    = 3;
  localparam int OP_BR   = 4;
  localparam int OP_BW   = 5;
  localparam int OP_N    = 6;
  localparam int NROW    = 22;

  typedef struct {
    int          op0;
    logic [31:0] a0;
    int          op1;
    logic [31:0] a1;
    logic        cs;
    logic [12:0] ad;
    logic        r0;
    logic        e0;
    logic        r1;
    logic        e1;
    int          d0;
    int          d1;
  } vec_t;

  logic            hclk = 1'b0;
  logic            hresetn = 1'b0;
  logic [31:0]     rom_rdata = '0;
  logic [AW-3:0]   rom_addr;
  logic            rom_cs;
  int              checks = 0;
  int              failures = 0;
  vec_t            tbl [NROW];

  ahb_rom_arb2_if i0 ();
  ahb_rom_arb2_if i1 ();

  assign i0.hready = i0.hreadyout;
  assign i1.hready = i1.hreadyout;

  ahb_rom_arb2 #(.p_AW(AW)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .p0        (i0),
    .p1        (i1),
    .rom_rdata (rom_rdata),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs)
  );

  always #5 hclk = ~hclk;

  function automatic logic [31:0] rdat(input logic [12:0] w);
    return 32'hC0DE_0000 ^ {19'b0, w};
  endfunction

  always @(posedge hclk)
    if (rom_cs) rom_rdata <= rdat(rom_addr);

  // {hsel, htrans, hwrite}
  function automatic logic [3:0] dec(input int op);
    case (op)
      OP_R:    return 4'b1_10_0;
      OP_W:    return 4'b1_10_1;
      OP_I:    return 4'b1_00_0;
      OP_BR:   return 4'b1_01_0;
      OP_BW:   return 4'b1_01_1;
      OP_N:    return 4'b0_10_0;
      default: return 4'b0_00_0;
    endcase
  endfunction

  function automatic vec_t mk(
    input int op0, input logic [31:0] a0,
    input int op1, input logic [31:0] a1,
    input logic cs, input logic [12:0] ad,
    input logic r0, input logic e0,
    input logic r1, input logic e1,
    input int d0, input int d1);
    vec_t v;
    v.op0 = op0; v.a0 = a0; v.op1 = op1; v.a1 = a1;
    v.cs = cs; v.ad = ad;
    v.r0 = r0; v.e0 = e0; v.r1 = r1; v.e1 = e1;
    v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic drive(input int op0, input logic [31:0] a0,
                       input int op1, input logic [31:0] a1);
    logic [3:0] c0, c1;
    c0 = dec(op0);
    c1 = dec(op1);
    {i0.hsel, i0.htrans, i0.hwrite} = c0;
    {i1.hsel, i1.htrans, i1.hwrite} = c1;
    i0.haddr = a0;
    i1.haddr = a1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_row(input int i, input vec_t v);
    chk($sformatf("r%0d_cs", i), 32'(rom_cs), 32'(v.cs));
    chk($sformatf("r%0d_addr", i), 32'(rom_addr), 32'(v.ad));
    chk($sformatf("r%0d_rdy0", i), 32'(i0.hreadyout), 32'(v.r0));
    chk($sformatf("r%0d_resp0", i), 32'(i0.hresp), {31'b0, v.e0});
    chk($sformatf("r%0d_rdy1", i), 32'(i1.hreadyout), 32'(v.r1));
    chk($sformatf("r%0d_resp1", i), 32'(i1.hresp), {31'b0, v.e1});
    if (v.d0 >= 0)
      chk($sformatf("r%0d_data0", i), i0.hrdata, rdat(13'(v.d0)));
    if (v.d1 >= 0)
      chk($sformatf("r%0d_data1", i), i1.hrdata, rdat(13'(v.d1)));
  endtask

  initial begin
    drive(OP_NONE, 0, OP_NONE, 0);

    tbl[0]  = mk(OP_NONE, 0, OP_NONE, 0, 0, 0, 1, 0, 1, 0, -1, -1);
    tbl[1]  = mk(OP_R, 'h10, OP_NONE, 0, 1, 'h4, 1, 0, 1, 0, -1, -1);
    tbl[2]  = mk(OP_NONE, 0, OP_R, 'h30, 1, 'hC, 1, 0, 1, 0, 4, -1);
    tbl[3]  = mk(OP_R, 'h20, OP_R, 'h40, 1, 'h8, 1, 0, 1, 0, -1, 12);
    tbl[4]  = mk(OP_R, 'h80, OP_NONE, 0, 1, 'h10, 1, 0, 0, 0, 8, -1);
    tbl[5]  = mk(OP_NONE, 0, OP_R, 'h44, 1, 'h20, 0, 0, 1, 0, -1, 16);
    tbl[6]  = mk(OP_R, 'h84, OP_NONE, 0, 1, 'h11, 1, 0, 0, 0, 32, -1);
    tbl[7]  = mk(OP_NONE, 0, OP_NONE, 0, 1, 'h21, 0, 0, 1, 0, -1, 17);
    tbl[8]  = mk(OP_NONE, 0, OP_NONE, 0, 0, 0, 1, 0, 1, 0, 33, -1);
    tbl[9]  = mk(OP_R, 'h0C, OP_W, 'h100, 1, 'h3, 1, 0, 1, 0, -1, -1);
    tbl[10] = mk(OP_R, 'h08, OP_NONE, 0, 1, 'h2, 1, 0, 0, 1, 3, -1);
    tbl[11] = mk(OP_NONE, 0, OP_NONE, 0, 0, 0, 1, 0, 1, 1, 2, -1);
    tbl[12] = mk(OP_I, 'h50, OP_I, 'h54, 0, 0, 1, 0, 1, 0, -1, -1);
    tbl[13] = mk(OP_BR, 'h58, OP_BW, 'h5C, 0, 0, 1, 0, 1, 0, -1, -1);
    tbl[14] = mk(OP_N, 'h60, OP_N, 'h64, 0, 0, 1, 0, 1, 0, -1, -1);
    tbl[15] = mk(OP_NONE, 0, OP_NONE, 0, 0, 0, 1, 0, 1, 0, -1, -1);
    tbl[16] = mk(OP_R, 'h200, OP_R, 'h204, 1, FX ? 13'h80 : 13'h81,
                 1, 0, 1, 0, -1, -1);
    tbl[17] = mk(OP_NONE, 0, OP_NONE, 0, 1, FX ? 13'h81 : 13'h80,
                 FX, 0, !FX, 0, FX ? 128 : -1, FX ? -1 : 129);
    tbl[18] = mk(OP_NONE, 0, OP_NONE, 0, 0, 0, 1, 0, 1, 0,
                 FX ? -1 : 128, FX ? 129 : -1);
    tbl[19] = mk(OP_R, 'h300, OP_R, 'h304, 1, FX ? 13'hC0 : 13'hC1,
                 1, 0, 1, 0, -1, -1);
    tbl[20] = mk(OP_NONE, 0, OP_NONE, 0, 1, FX ? 13'hC1 : 13'hC0,
                 FX, 0, !FX, 0, FX ? 192 : -1, FX ? -1 : 193);
    tbl[21] = mk(OP_NONE, 0, OP_NONE, 0, 0, 0, 1, 0, 1, 0,
                 FX ? -1 : 192, FX ? 193 : -1);

    #2;
    chk("rst_rdy0", 32'(i0.hreadyout), 32'd1);
    chk("rst_rdy1", 32'(i1.hreadyout), 32'd1);
    chk("rst_resp0", 32'(i0.hresp), 32'd0);
    chk("rst_resp1", 32'(i1.hresp), 32'd0);
    chk("rst_cs", 32'(rom_cs), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    #10 hresetn = 1'b1;

    for (int i = 0; i < NROW; i++) begin
      @(posedge hclk);
      #1 drive(tbl[i].op0, tbl[i].a0, tbl[i].op1, tbl[i].a1);
      @(negedge hclk);
      chk_row(i, tbl[i]);
    end

    // Put port 1 into WAIT, then reset in the middle of its stall.
    @(posedge hclk);
    #1 drive(OP_NONE, 0, OP_R, 'h10);
    @(negedge hclk);
    chk("pre_cs", 32'(rom_cs), 32'd1);
    chk("pre_addr", 32'(rom_addr), 32'h4);

    @(posedge hclk);
    #1 drive(OP_R, 'h400, OP_R, 'h404);
    @(negedge hclk);
    chk("cf_addr", 32'(rom_addr), 32'h100);

    @(posedge hclk);
    #1 drive(OP_R, 'h14, OP_NONE, 0);
    #1;
    chk("wt_rdy1", 32'(i1.hreadyout), 32'd0);
    chk("wt_cs", 32'(rom_cs), 32'd1);
    chk("wt_addr", 32'(rom_addr), 32'h101);
    #1 hresetn = 1'b0;
    #1;
    chk("mr_rdy1", 32'(i1.hreadyout), 32'd1);
    chk("mr_rdy0", 32'(i0.hreadyout), 32'd1);
    chk("mr_cs", 32'(rom_cs), 32'd0);
    chk("mr_addr", 32'(rom_addr), 32'd0);
    chk("mr_resp1", 32'(i1.hresp), 32'd0);
    drive(OP_NONE, 0, OP_NONE, 0);
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    chk("rl_rdy1", 32'(i1.hreadyout), 32'd1);

    @(posedge hclk);
    #1 drive(OP_R, 'h14, OP_NONE, 0);
    @(negedge hclk);
    chk("ar_cs", 32'(rom_cs), 32'd1);
    chk("ar_addr", 32'(rom_addr), 32'h5);
    chk("ar_rdy0", 32'(i0.hreadyout), 32'd1);

    @(posedge hclk);
    #1 drive(OP_NONE, 0, OP_NONE, 0);
    @(negedge hclk);
    chk("ad_rdy0", 32'(i0.hreadyout), 32'd1);
    chk("ad_data0", i0.hrdata, rdat(13'h5));
    chk("ad_cs", 32'(rom_cs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
